// File: rtl/button_port_pkg.sv
// Shared SOC I/O package: register offsets for the button and LED peripherals
// and the bus-access decode used by the button port.
package button_port_pkg;

  localparam int unsigned IO_DATA_W = 32;

  localparam logic [1:0] BTN_ADDR_STATE   = 2'd0;
  localparam logic [1:0] BTN_ADDR_PRESSED = 2'd1;
  localparam logic [1:0] BTN_ADDR_IRQ_EN  = 2'd2;
  localparam logic [1:0] BTN_ADDR_RAW     = 2'd3;

  localparam logic [1:0] LED_ADDR_STATE  = 2'd0;
  localparam logic [1:0] LED_ADDR_SET    = 2'd1;
  localparam logic [1:0] LED_ADDR_CLR    = 2'd2;
  localparam logic [1:0] LED_ADDR_TOGGLE = 2'd3;

  typedef struct packed {
    logic rd;
    logic wr_pressed;
    logic wr_irq_en;
  } btn_access_t;

  // Writes to STATE and RAW decode to nothing, so they fall away here.
  function automatic btn_access_t btn_decode(input logic       sel,
                                             input logic       rstrb,
                                             input logic       wstrb,
                                             input logic [1:0] addr);
    btn_access_t acc;
    acc.rd         = sel & rstrb;
    acc.wr_pressed = sel & wstrb & (addr == BTN_ADDR_PRESSED);
    acc.wr_irq_en  = sel & wstrb & (addr == BTN_ADDR_IRQ_EN);
    return acc;
  endfunction

endpackage

// File: rtl/button_port_if.sv
// CPU-side register bus of the button port: strobed reads/writes, registered read data.
interface button_port_if;
  import button_port_pkg::*;

  logic                 io_sel;
  logic [1:0]           io_addr;
  logic                 io_rstrb;
  logic                 io_wstrb;
  logic [IO_DATA_W-1:0] io_wdata;
  logic [IO_DATA_W-1:0] io_rdata;

  modport master (
    output io_sel, io_addr, io_rstrb, io_wstrb, io_wdata,
    input  io_rdata
  );

  modport slave (
    input  io_sel, io_addr, io_rstrb, io_wstrb, io_wdata,
    output io_rdata
  );
endinterface

// File: rtl/button_debounce.sv
// One button: two-flop synchronizer followed by a stability counter that accepts
// a level change only after DEBOUNCE_CYCLES consecutive differing samples.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic button_i,
  output logic sync_o,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             differs;
  logic             accept;

  // NOTE: every always_comb output gets a default before any branch, so no path
  // can leave a value unassigned and infer a latch.
  always_comb begin
    sync1_d = button_i;
    sync2_d = sync1_q;
    differs = (sync2_q != level_q);
    accept  = differs && (cnt_q == CNT_MAX);
    level_d = level_q;
    cnt_d   = '0;
    if (accept) begin
      level_d = sync2_q;
    end else if (differs) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, exactly as the hardware does.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_o  = sync2_q;
  assign level_o = level_q;
  // High in the cycle whose edge moves the debounced level from 0 to 1.
  assign rise_o  = accept & sync2_q;

endmodule

// File: rtl/button_port.sv
// Memory-mapped push-button peripheral: debounced STATE, sticky W1C PRESSED,
// IRQ_EN mask, RAW synchronized levels, and a registered level interrupt.
module button_port
  import button_port_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [0:N_BUTTONS-1] BUTTONS,
  button_port_if.slave         io,
  output logic                 irq
);

  logic [N_BUTTONS-1:0] sync_vec;
  logic [N_BUTTONS-1:0] level_vec;
  logic [N_BUTTONS-1:0] rise_vec;

  for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .CLK     (CLK),
      .RESET   (RESET),
      .button_i(BUTTONS[gi]),
      .sync_o  (sync_vec[gi]),
      .level_o (level_vec[gi]),
      .rise_o  (rise_vec[gi])
    );
  end

  logic [N_BUTTONS-1:0] pressed_q, pressed_d;
  logic [N_BUTTONS-1:0] irq_en_q, irq_en_d;
  logic [IO_DATA_W-1:0] rdata_q, rdata_d;
  logic                 irq_q, irq_d;
  logic [N_BUTTONS-1:0] rd_sel;
  btn_access_t          acc;

  always_comb begin
    acc = btn_decode(io.io_sel, io.io_rstrb, io.io_wstrb, io.io_addr);

    // A new debounced press is OR-ed in after the clear, so it wins a collision.
    pressed_d = pressed_q;
    if (acc.wr_pressed) begin
      pressed_d = pressed_q & ~io.io_wdata[N_BUTTONS-1:0];
    end
    pressed_d = pressed_d | rise_vec;

    irq_en_d = irq_en_q;
    if (acc.wr_irq_en) begin
      irq_en_d = io.io_wdata[N_BUTTONS-1:0];
    end

    // Reads sample the current registers, so a same-cycle write is not yet visible.
    case (io.io_addr)
      BTN_ADDR_STATE:   rd_sel = level_vec;
      BTN_ADDR_PRESSED: rd_sel = pressed_q;
      BTN_ADDR_IRQ_EN:  rd_sel = irq_en_q;
      default:          rd_sel = sync_vec;
    endcase

    rdata_d = rdata_q;
    if (acc.rd) begin
      rdata_d                = '0;
      rdata_d[N_BUTTONS-1:0] = rd_sel;
    end

    irq_d = |(pressed_q & irq_en_q);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pressed_q <= '0;
      irq_en_q  <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      pressed_q <= pressed_d;
      irq_en_q  <= irq_en_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign io.io_rdata = rdata_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_button_port.sv
// Bench for button_port: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_button_port;
  import button_port_pkg::*;

  localparam int NB  = 3;
  localparam int DEB = 4;
  localparam logic [31:0] WIN_MASK = (32'd1 << DEB) - 32'd1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [0:NB-1] buttons = '0;
  logic          irq;

  button_port_if bus();

  button_port #(
    .N_BUTTONS      (NB),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLK    (clk),
    .RESET  (rst),
    .BUTTONS(buttons),
    .io     (bus),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model. Each button keeps a window of its recent synchronized
  // samples; the level flips once the last DEB samples all disagree with it.
  logic [NB-1:0] m_s1, m_s2, m_level, m_pressed, m_irq_en, m_rise, m_val;
  logic [31:0]   m_win [NB];
  logic [31:0]   m_rdata;
  logic          m_irq;

  initial begin
    m_s1 = '0; m_s2 = '0; m_level = '0; m_pressed = '0; m_irq_en = '0;
    m_rdata = '0; m_irq = 1'b0;
    for (int i = 0; i < NB; i++) m_win[i] = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_pressed = '0; m_irq_en = '0;
      m_rdata = '0; m_irq = 1'b0;
      for (int i = 0; i < NB; i++) m_win[i] = '0;
    end else begin
      if (bus.io_sel && bus.io_rstrb) begin
        case (bus.io_addr)
          2'd0:    m_val = m_level;
          2'd1:    m_val = m_pressed;
          2'd2:    m_val = m_irq_en;
          default: m_val = m_s2;
        endcase
        m_rdata = {29'd0, m_val};
      end
      m_irq = |(m_pressed & m_irq_en);
      m_rise = '0;
      for (int i = 0; i < NB; i++) begin
        m_win[i] = (m_win[i] << 1) | {31'd0, m_s2[i]};
        if (!m_level[i] && ((m_win[i] & WIN_MASK) == WIN_MASK)) begin
          m_level[i] = 1'b1;
          m_rise[i]  = 1'b1;
        end else if (m_level[i] && ((m_win[i] & WIN_MASK) == 32'd0)) begin
          m_level[i] = 1'b0;
        end
      end
      if (bus.io_sel && bus.io_wstrb && bus.io_addr == 2'd1)
        m_pressed = m_pressed & ~bus.io_wdata[NB-1:0];
      m_pressed = m_pressed | m_rise;
      if (bus.io_sel && bus.io_wstrb && bus.io_addr == 2'd2)
        m_irq_en = bus.io_wdata[NB-1:0];
      m_s2 = m_s1;
      for (int i = 0; i < NB; i++) m_s1[i] = buttons[i];
    end
  end

  logic cmp_en = 1'b0;

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("model_rdata", bus.io_rdata, m_rdata);
      check("model_irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  task automatic bus_idle();
    bus.io_sel   = 1'b0;
    bus.io_rstrb = 1'b0;
    bus.io_wstrb = 1'b0;
    bus.io_addr  = 2'd0;
    bus.io_wdata = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] d);
    bus.io_sel = 1'b1; bus.io_addr = a; bus.io_rstrb = 1'b1;
    @(negedge clk);
    bus_idle();
    d = bus.io_rdata;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] w);
    bus.io_sel = 1'b1; bus.io_addr = a; bus.io_wstrb = 1'b1; bus.io_wdata = w;
    @(negedge clk);
    bus_idle();
  endtask

  logic [31:0] d;

  initial begin
    bus_idle();
    @(posedge clk);
    cmp_en = 1'b1;
    cycles(3);
    check("reset_rdata", bus.io_rdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    rst = 1'b0;
    cycles(2);

    // Clean press of button 0: level moves on the 6th edge after the change.
    buttons[0] = 1'b1;
    cycles(5);
    do_read(BTN_ADDR_STATE, d);   check("press_state_edge6_pre", d, 32'h0);
    do_read(BTN_ADDR_STATE, d);   check("press_state_after6", d, 32'h1);
    do_read(BTN_ADDR_PRESSED, d); check("press_pressed", d, 32'h1);
    check("press_irq_masked", {31'd0, irq}, 32'h0);
    cycles(12);
    buttons[0] = 1'b0;
    cycles(10);
    do_read(BTN_ADDR_PRESSED, d); check("release_keeps_pressed", d, 32'h1);
    do_write(BTN_ADDR_PRESSED, 32'h1);
    do_read(BTN_ADDR_PRESSED, d); check("w1c_clear", d, 32'h0);

    // Two-cycle glitch on button 1.
    buttons[1] = 1'b1;
    cycles(2);
    buttons[1] = 1'b0;
    do_read(BTN_ADDR_RAW, d);     check("glitch_raw", d, 32'h2);
    cycles(10);
    do_read(BTN_ADDR_STATE, d);   check("glitch_state", d, 32'h0);
    do_read(BTN_ADDR_PRESSED, d); check("glitch_pressed", d, 32'h0);

    // Interrupt on button 2.
    do_write(BTN_ADDR_IRQ_EN, 32'h4);
    do_read(BTN_ADDR_IRQ_EN, d);  check("irq_en_read", d, 32'h4);
    buttons[2] = 1'b1;
    cycles(6);
    check("irq_before", {31'd0, irq}, 32'h0);
    cycles(1);
    check("irq_asserted", {31'd0, irq}, 32'h1);
    do_write(BTN_ADDR_PRESSED, 32'h4);
    check("irq_one_after_w1c", {31'd0, irq}, 32'h1);
    cycles(1);
    check("irq_two_after_w1c", {31'd0, irq}, 32'h0);
    buttons[2] = 1'b0;
    cycles(8);
    do_write(BTN_ADDR_IRQ_EN, 32'h0);

    // W1C colliding with a new press edge on bit 0.
    buttons[0] = 1'b1;
    cycles(5);
    do_write(BTN_ADDR_PRESSED, 32'h1);
    do_read(BTN_ADDR_PRESSED, d); check("collide_set_wins", d, 32'h1);
    do_write(BTN_ADDR_PRESSED, 32'h1);
    do_read(BTN_ADDR_PRESSED, d); check("collide_then_clear", d, 32'h0);
    buttons[0] = 1'b0;
    cycles(8);

    // Reset in the middle of a debounce, button held throughout.
    buttons[0] = 1'b1;
    cycles(2);
    rst = 1'b1;
    cycles(2);
    for (int a = 0; a < 4; a++) begin
      do_read(2'(a), d);
      check("in_reset_read", d, 32'h0);
    end
    check("in_reset_irq", {31'd0, irq}, 32'h0);
    rst = 1'b0;
    cycles(5);
    do_read(BTN_ADDR_PRESSED, d); check("post_reset_edge6_pre", d, 32'h0);
    do_read(BTN_ADDR_PRESSED, d); check("post_reset_pressed", d, 32'h1);

    // Writes to read-only offsets, and upper data bits.
    do_write(BTN_ADDR_STATE, 32'hFFFF_FFFF);
    do_write(BTN_ADDR_RAW, 32'hFFFF_FFFF);
    do_read(BTN_ADDR_STATE, d);   check("ro_state", d, 32'h1);
    do_read(BTN_ADDR_RAW, d);     check("ro_raw", d, 32'h1);
    do_write(BTN_ADDR_IRQ_EN, 32'hFFFF_FFFF);
    do_read(BTN_ADDR_IRQ_EN, d);  check("irq_en_masked", d, 32'h7);

    // Randomized phase: button chatter, mixed strobes, occasional reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        int b;
        b = int'($urandom_range(0, NB - 1));
        buttons[b] = ~buttons[b];
      end
      rst          = ($urandom_range(0, 399) == 0);
      bus.io_sel   = ($urandom_range(0, 3) != 0);
      bus.io_rstrb = ($urandom_range(0, 2) == 0);
      bus.io_wstrb = ($urandom_range(0, 3) == 0);
      bus.io_addr  = 2'($urandom_range(0, 3));
      bus.io_wdata = ($urandom_range(0, 1) == 0) ? $urandom : 32'(1 << $urandom_range(0, NB - 1));
      @(negedge clk);
    end
    rst = 1'b0;
    bus_idle();
    cycles(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_port.md
BUTTON_PORT -- requirements
Module: button_port

Interface
REQ-001 Parameter N_BUTTONS, default 3, number of push-button inputs (1..8).
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, consecutive stable CLK cycles required to accept a level change (>=2).
REQ-003 CLK  input  1  system clock; single clock domain.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 BUTTONS  input  [0:N_BUTTONS-1]  asynchronous raw button levels, 1 = pressed.
REQ-006 io_sel  input  1  peripheral selected by CPU address decode.
REQ-007 io_addr  input  2  word offset: 0 STATE, 1 PRESSED, 2 IRQ_EN, 3 RAW.
REQ-008 io_rstrb  input  1  read strobe, one-cycle pulse.
REQ-009 io_wstrb  input  1  write strobe, one-cycle pulse.
REQ-010 io_wdata  input  32  write data.
REQ-011 io_rdata  output  32  registered read data.
REQ-012 irq  output  1  registered interrupt request, level.

Function
REQ-013 Each BUTTONS bit SHALL pass a 2-flop synchronizer; the second-stage value is "sync".
REQ-014 Per button, a counter SHALL clear whenever sync equals the debounced level, otherwise increment; on reaching DEBOUNCE_CYCLES-1 the debounced level SHALL take sync and the counter SHALL clear.
REQ-015 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); counter SHALL never wrap.
REQ-016 Total latency BUTTONS change to STATE change SHALL be exactly DEBOUNCE_CYCLES+2 cycles for a clean step.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES sync cycles SHALL leave STATE unchanged.
REQ-018 A debounced 0->1 transition SHALL set the sticky PRESSED bit; 1->0 transitions SHALL not affect PRESSED.
REQ-019 Write to PRESSED (io_sel & io_wstrb, addr 1) SHALL clear bits where io_wdata is 1 (W1C).
REQ-020 Same-cycle set and W1C of one PRESSED bit: set SHALL win.
REQ-021 Write to IRQ_EN (addr 2) SHALL load io_wdata[N_BUTTONS-1:0]; writes to addr 0 and 3 SHALL be ignored.
REQ-022 Read (io_sel & io_rstrb) SHALL present the addressed register, zero-extended, on io_rdata the following cycle; io_rdata SHALL hold until the next read.
REQ-023 Read of PRESSED SHALL have no side effect.
REQ-024 irq SHALL equal the registered OR of (PRESSED & IRQ_EN), one cycle after either changes.
REQ-025 Strobes with io_sel=0 SHALL have no effect; simultaneous io_rstrb and io_wstrb SHALL both be honoured, read returning the pre-write value.
REQ-026 Bit i of every register SHALL correspond to BUTTONS[i].

Reset
REQ-027 While RESET=1 at a CLK edge: synchronizer flops, debounced levels, counters, PRESSED, IRQ_EN, io_rdata and irq SHALL become 0.
REQ-028 RESET asserted mid-debounce SHALL discard the partial count; a button held through reset SHALL produce a PRESSED set DEBOUNCE_CYCLES+2 cycles after RESET deasserts.

Structure
REQ-029 Register offset constants (STATE, PRESSED, IRQ_EN, RAW) SHALL live in the shared SOC I/O package alongside LED offsets.
REQ-030 Per-button synchronizer+counter SHALL be one sub-module, button_debounce, instantiated N_BUTTONS times via generate.
REQ-031 Implementation SHALL be 120-400 lines, synthesizable, no latches, no async reset.

Verification (bench: N_BUTTONS=3, DEBOUNCE_CYCLES=4)
REQ-032 Clean press of BUTTONS[0] held 20 cycles -> STATE=3'b001 after 6 cycles; PRESSED reads 0x1; irq stays 0 (IRQ_EN=0).
REQ-033 BUTTONS[1] pulse of 2 cycles -> STATE and PRESSED remain 0; RAW read during pulse shows 0x2.
REQ-034 IRQ_EN=0x4, press BUTTONS[2] -> irq=1 one cycle after PRESSED bit2 sets; write PRESSED 0x4 -> irq=0 two cycles later.
REQ-035 W1C of bit0 in the same cycle as a new bit0 press edge -> PRESSED bit0 remains 1.
REQ-036 RESET asserted 2 cycles into a BUTTONS[0] press, released with button held -> all registers read 0 during reset; PRESSED=0x1 six cycles after release.
REQ-037 Write 0xFFFF_FFFF to addr 0 and 3, then read both -> values unchanged; upper io_rdata bits always 0.
